// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: stall/flush control for the F/D/E/M stage registers.
// Handles load-use interlocks, execute redirects, fetch waits and multi-cycle MUL/DIV occupancy.
module hazard_sequencer #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned DIV_LAT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_valid,
   input  logic        e_is_load,
   input  logic        e_is_mul,
   input  logic        e_is_div,
   input  logic        e_branch_taken,
   input  logic [63:0] e_target,
   input  logic [4:0]  e_dst,
   input  logic        d_valid,
   input  logic [4:0]  d_rs1,
   input  logic [4:0]  d_rs2,
   input  logic        i_busy,
   input  logic        m_busy,
   output logic        stall_f,
   output logic        stall_d,
   output logic        stall_e,
   output logic        stall_m,
   output logic        flush_d,
   output logic        flush_e,
   output logic        flush_m,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic        mdu_done
);

   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 32'd2);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 32'd2);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MDU        = 2'd1,
      REDIR_WAIT = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [63:0]       rpc_q, rpc_d;

   logic        sf_c, sd_c, se_c, sm_c;
   logic        fd_c, fe_c, fm_c;
   logic        rv_c, done_c;
   logic [63:0] pc_c;
   logic        load_use_c;

   // A zero e_dst never matches, so x0 sources cannot raise an interlock.
   assign load_use_c = e_valid & e_is_load & (e_dst != 5'd0) & d_valid &
                       ((d_rs1 == e_dst) | (d_rs2 == e_dst));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         rpc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rpc_q   <= rpc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rpc_d   = rpc_q;
      sf_c    = 1'b0;
      sd_c    = 1'b0;
      se_c    = 1'b0;
      sm_c    = 1'b0;
      fd_c    = 1'b0;
      fe_c    = 1'b0;
      fm_c    = 1'b0;
      rv_c    = 1'b0;
      done_c  = 1'b0;
      pc_c    = '0;

      unique case (state_q)
         RUN: begin
            if (m_busy) begin
               {sf_c, sd_c, se_c, sm_c} = 4'b1111;
            end else if (e_valid & (e_is_mul | e_is_div)) begin
               {sf_c, sd_c, se_c, fm_c} = 4'b1111;
               cnt_d   = e_is_div ? DIV_INIT : MUL_INIT;
               state_d = MDU;
            end else if (e_valid & e_branch_taken) begin
               fd_c = 1'b1;
               fe_c = 1'b1;
               rv_c = 1'b1;
               pc_c = e_target;
               if (i_busy) begin
                  sf_c    = 1'b1;
                  rpc_d   = e_target;
                  state_d = REDIR_WAIT;
               end
            end else begin
               if (load_use_c) begin
                  sf_c = 1'b1;
                  sd_c = 1'b1;
                  fe_c = 1'b1;
               end
               // Decode hold takes precedence over the fetch-wait bubble.
               if (i_busy) begin
                  sf_c = 1'b1;
                  fd_c = ~load_use_c;
               end
            end
         end

         MDU: begin
            if (m_busy) begin
               {sf_c, sd_c, se_c, sm_c} = 4'b1111;
            end else if (cnt_q != '0) begin
               {sf_c, sd_c, se_c, fm_c} = 4'b1111;
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               done_c  = 1'b1;
               state_d = RUN;
            end
         end

         REDIR_WAIT: begin
            rv_c = 1'b1;
            pc_c = rpc_q;
            if (m_busy) begin
               {sf_c, sd_c, se_c, sm_c} = 4'b1111;
            end else begin
               // The instruction returning now is stale and is always discarded.
               fd_c = 1'b1;
               sf_c = i_busy;
               if (!i_busy) state_d = RUN;
            end
         end

         default: state_d = RUN;
      endcase
   end

   assign stall_f        = sf_c & ~reset;
   assign stall_d        = sd_c & ~reset;
   assign stall_e        = se_c & ~reset;
   assign stall_m        = sm_c & ~reset;
   assign flush_d        = fd_c & ~reset;
   assign flush_e        = fe_c & ~reset;
   assign flush_m        = fm_c & ~reset;
   assign redirect_valid = rv_c & ~reset;
   assign mdu_done       = done_c & ~reset;
   assign redirect_pc    = reset ? 64'd0 : pc_c;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// compared against a behavioural model of the pipeline controller.
module tb_hazard_sequencer;

   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned DIV_LAT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_valid, e_is_load, e_is_mul, e_is_div, e_branch_taken;
   logic [63:0] e_target;
   logic [4:0]  e_dst, d_rs1, d_rs2;
   logic        d_valid, i_busy, m_busy;
   logic        stall_f, stall_d, stall_e, stall_m;
   logic        flush_d, flush_e, flush_m;
   logic        redirect_valid, mdu_done;
   logic [63:0] redirect_pc;

   always #5 clk = ~clk;

   hazard_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(5)) dut (
      .clk(clk), .reset(reset),
      .e_valid(e_valid), .e_is_load(e_is_load), .e_is_mul(e_is_mul), .e_is_div(e_is_div),
      .e_branch_taken(e_branch_taken), .e_target(e_target), .e_dst(e_dst),
      .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
      .i_busy(i_busy), .m_busy(m_busy),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mdu_done(mdu_done)
   );

   // Bit order: {sf, sd, se, sm, fd, fe, fm, rv, done}
   logic [8:0] obs;
   assign obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m,
                 redirect_valid, mdu_done};

   int checks   = 0;
   int failures = 0;

   // Model state: remaining MDU cycles (including the current one) and a pending redirect.
   int          mdu_left;
   bit          redir_pend;
   logic [63:0] redir_addr;
   logic [8:0]  last_obs;

   task automatic model_reset();
      mdu_left   = 0;
      redir_pend = 1'b0;
      redir_addr = '0;
   endtask

   task automatic model_eval(output logic [8:0] exp_o, output logic [63:0] exp_pc);
      bit sf, sd, se, sm, fd, fe, fm, rv, dn, lu;
      sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fm = 0; rv = 0; dn = 0;
      exp_pc = '0;
      lu = e_valid && e_is_load && (e_dst != 0) && d_valid && (d_rs1 == e_dst || d_rs2 == e_dst);
      if (reset) begin
         exp_o = '0;
         return;
      end
      if (m_busy) begin
         sf = 1; sd = 1; se = 1; sm = 1;
         if (redir_pend) begin rv = 1; exp_pc = redir_addr; end
      end else if (mdu_left > 0) begin
         if (mdu_left == 1) dn = 1;
         else begin sf = 1; sd = 1; se = 1; fm = 1; end
      end else if (redir_pend) begin
         rv = 1; exp_pc = redir_addr; fd = 1; sf = i_busy;
      end else if (e_valid && (e_is_mul || e_is_div)) begin
         sf = 1; sd = 1; se = 1; fm = 1;
      end else if (e_valid && e_branch_taken) begin
         fd = 1; fe = 1; rv = 1; exp_pc = e_target; sf = i_busy;
      end else begin
         if (lu) begin sf = 1; sd = 1; fe = 1; end
         if (i_busy) begin sf = 1; if (!lu) fd = 1; end
      end
      exp_o = {sf, sd, se, sm, fd, fe, fm, rv, dn};
   endtask

   task automatic model_advance();
      if (reset) model_reset();
      else if (m_busy) begin
      end else if (mdu_left > 0) mdu_left--;
      else if (redir_pend) begin
         if (!i_busy) redir_pend = 1'b0;
      end else if (e_valid && (e_is_mul || e_is_div)) begin
         mdu_left = int'(e_is_div ? DIV_LAT : MUL_LAT) - 1;
      end else if (e_valid && e_branch_taken && i_busy) begin
         redir_pend = 1'b1;
         redir_addr = e_target;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [8:0]  exp_o;
      logic [63:0] exp_pc;
      model_eval(exp_o, exp_pc);
      checks++;
      assert (obs === exp_o) else begin
         failures++;
         $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp_o);
      end
      checks++;
      assert (redirect_pc === exp_pc) else begin
         failures++;
         $error("FAIL %s redirect_pc observed=%h expected=%h", tag, redirect_pc, exp_pc);
      end
      last_obs = obs;
   endtask

   task automatic check_val(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Called at the falling edge: check, advance the model, move to the next falling edge.
   task automatic cycle(input string tag);
      #1;
      check_outputs(tag);
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      e_valid = 0; e_is_load = 0; e_is_mul = 0; e_is_div = 0; e_branch_taken = 0;
      e_target = '0; e_dst = '0; d_valid = 0; d_rs1 = '0; d_rs2 = '0;
      i_busy = 0; m_busy = 0;
   endtask

   // Runs an MDU op starting now; reports cycle index of mdu_done and stall_e count.
   task automatic run_mdu(input bit is_div, input int frz_at, input int frz_len,
                          input string tag, output int done_at, output int se_cnt);
      done_at = 0;
      se_cnt  = 0;
      idle();
      e_valid = 1; e_is_div = is_div; e_is_mul = !is_div;
      for (int k = 1; k <= 40; k++) begin
         m_busy = (frz_len > 0) && (k >= frz_at) && (k < frz_at + frz_len);
         cycle(tag);
         if (last_obs[6]) se_cnt++;
         if (last_obs[0]) begin
            done_at = k;
            break;
         end
         e_valid = 0; e_is_div = 0; e_is_mul = 0;
      end
      idle();
   endtask

   int done_at, se_cnt, done_seen;

   initial begin
      model_reset();
      idle();
      reset = 1;
      e_valid = 1; e_branch_taken = 1; e_target = 64'h1234; i_busy = 1; m_busy = 1;
      #1 check_outputs("reset_hold");
      @(negedge clk);
      reset = 0;
      idle();
      cycle("after_reset");

      // Load-use interlock, then x0 destination
      e_valid = 1; e_is_load = 1; e_dst = 5; d_valid = 1; d_rs1 = 3; d_rs2 = 5;
      cycle("load_use");
      checks++;
      assert (last_obs === 9'b110001000) else begin
         failures++;
         $error("FAIL load_use_const observed=%b expected=%b", last_obs, 9'b110001000);
      end
      e_dst = 0; d_rs1 = 0; d_rs2 = 0;
      cycle("load_use_x0");
      idle();
      e_valid = 1; e_is_load = 1; e_dst = 7; d_valid = 1; d_rs1 = 7; i_busy = 1;
      cycle("load_use_fetch");
      idle();

      // Branch with fetch idle
      e_valid = 1; e_branch_taken = 1; e_target = 64'h8000_0040;
      cycle("br_idle");
      idle();
      cycle("br_idle_next");

      // Branch while fetch waits for 3 cycles; e_target changes meanwhile
      e_valid = 1; e_branch_taken = 1; e_target = 64'h8000_0040; i_busy = 1;
      cycle("br_wait0");
      e_valid = 1; e_branch_taken = 0; e_target = 64'hdead_beef_0000_1000;
      cycle("br_wait1");
      cycle("br_wait2");
      i_busy = 0;
      #1;
      checks++;
      assert (redirect_pc === 64'h8000_0040) else begin
         failures++;
         $error("FAIL br_wait_pc observed=%h expected=%h", redirect_pc, 64'h8000_0040);
      end
      cycle("br_wait_drop");
      idle();
      e_target = 64'h5555_0000;
      cycle("br_wait_run");

      // Divide / multiply occupancy, with and without freeze
      run_mdu(1, 0, 0, "div", done_at, se_cnt);
      check_val("div_done_cycle", done_at, 16);
      check_val("div_stall_e_cycles", se_cnt, 15);
      run_mdu(1, 5, 2, "div_frz", done_at, se_cnt);
      check_val("div_frz_done_cycle", done_at, 18);
      run_mdu(0, 0, 0, "mul", done_at, se_cnt);
      check_val("mul_done_cycle", done_at, 3);
      cycle("mdu_idle");

      // Freeze beats load-use and redirect; redirect issues on release
      e_valid = 1; e_is_load = 1; e_dst = 5; d_valid = 1; d_rs1 = 5;
      e_branch_taken = 1; e_target = 64'h8000_0080; m_busy = 1;
      cycle("freeze");
      m_busy = 0;
      cycle("freeze_release");
      idle();
      cycle("freeze_idle");

      // Async reset in the middle of a divide (counter at 7)
      e_valid = 1; e_is_div = 1;
      cycle("rst_div_start");
      idle();
      for (int k = 0; k < 7; k++) cycle("rst_div_run");
      #2 reset = 1;
      #1 check_outputs("rst_async");
      model_reset();
      @(negedge clk);
      reset = 0;
      done_seen = 0;
      for (int k = 0; k < 20; k++) begin
         cycle("rst_after");
         if (last_obs[0]) done_seen++;
      end
      check_val("rst_no_done", done_seen, 0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         e_valid        = ($urandom_range(0, 3) != 0);
         e_is_load      = ($urandom_range(0, 3) == 0);
         e_is_mul       = ($urandom_range(0, 9) == 0);
         e_is_div       = ($urandom_range(0, 19) == 0);
         e_branch_taken = ($urandom_range(0, 5) == 0);
         e_target       = {$urandom, $urandom};
         e_dst          = 5'($urandom_range(0, 7));
         d_valid        = ($urandom_range(0, 3) != 0);
         d_rs1          = 5'($urandom_range(0, 7));
         d_rs2          = 5'($urandom_range(0, 7));
         i_busy         = ($urandom_range(0, 2) == 0);
         m_busy         = ($urandom_range(0, 7) == 0);
         cycle("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage RV64 core: sequences stall/flush for fetch, decode, execute and memory stage registers.
- Resolves load-use hazards, branch/jump redirects from execute (including redirects raised while fetch is still waiting on memory), and multi-cycle MUL/DIV occupancy of the execute stage.
- Sits beside the stage registers and drives their enable/clear inputs.

Parameters:
- MUL_LAT, 3, execute cycles occupied by a multiply (legal range ≥2).
- DIV_LAT, 16, execute cycles occupied by a divide (legal range ≥2).
- CNT_W, 5, width of the occupancy counter; must hold max(MUL_LAT,DIV_LAT)-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- e_valid  in  1  execute stage holds a valid instruction.
- e_is_load  in  1  execute instruction is a load.
- e_is_mul  in  1  execute instruction is MUL*.
- e_is_div  in  1  execute instruction is DIV*/REM*.
- e_branch_taken  in  1  execute resolved a taken branch or jump.
- e_target  in  64  redirect PC from execute.
- e_dst  in  5  execute destination register.
- d_valid  in  1  decode holds a valid instruction.
- d_rs1, d_rs2  in  5 each  decode source registers.
- i_busy  in  1  instruction fetch outstanding.
- m_busy  in  1  data memory access outstanding in memory stage.
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the corresponding stage register.
- flush_d, flush_e, flush_m  out  1 each  load a bubble into the corresponding stage register at the next edge.
- redirect_valid  out  1  fetch must take redirect_pc.
- redirect_pc  out  64  redirect target.
- mdu_done  out  1  MUL/DIV result is valid in execute this cycle.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high.
- Reset: state=RUN, cnt=0, redirect_pc register=0. All outputs are 0 while reset is high. Reset during MDU or REDIR_WAIT aborts to RUN with no mdu_done pulse.
- States: RUN, MDU, REDIR_WAIT. All outputs are combinational from state plus inputs, except redirect_pc in REDIR_WAIT, which is registered.
- Global freeze (all states): m_busy=1 → stall_f, stall_d, stall_e and stall_m all =1, with no flushes.
  - cnt and state hold.
  - redirect_valid stays asserted if the state is REDIR_WAIT.
  - Freeze has the highest priority.
- RUN priority (highest first, after freeze):
  1. MDU start: e_valid & (e_is_mul|e_is_div).
     - Assert stall_f, stall_d, stall_e and flush_m.
     - Next state MDU; cnt ← LAT-2, where LAT is DIV_LAT if e_is_div, else MUL_LAT. mul and div together are treated as div.
  2. Redirect: e_valid & e_branch_taken.
     - Assert flush_d, flush_e, redirect_valid; redirect_pc=e_target.
     - If i_busy=1, latch e_target, assert stall_f, next state REDIR_WAIT.
  3. Load-use: e_valid & e_is_load & e_dst≠0 & d_valid & (d_rs1==e_dst | d_rs2==e_dst).
     - Assert stall_f, stall_d, flush_e.
  4. Fetch wait: i_busy=1 → stall_f, flush_d.
  5. Otherwise all outputs are 0.
  - Fetch wait combines with rule 3 as the union of both rule sets; stall_d wins over flush_d.
- MDU:
  - While cnt≠0: stall_f, stall_d, stall_e and flush_m; cnt decrements by 1 each unfrozen cycle.
  - When cnt==0: mdu_done=1, no stalls, next state RUN. The instruction advances to memory at this edge.
  - Total execute occupancy is exactly LAT cycles, excluding frozen cycles.
  - Branch/load-use inputs are ignored in MDU.
- REDIR_WAIT:
  - redirect_valid=1, redirect_pc=latched value.
  - While i_busy=1: stall_f=1, flush_d=1.
  - When i_busy=0: the returned stale instruction is discarded (flush_d=1), fetch accepts the redirect at this edge, next state RUN.
- A decode instruction with rs=x0 never triggers load-use.

Test Plan:
- Load-use: e_valid=1, e_is_load=1, e_dst=5; d_valid=1, d_rs2=5 → one cycle of stall_f=stall_d=flush_e=1. With e_dst=0 → no stall.
- Branch, fetch idle: e_branch_taken=1, e_target=0x8000_0040, i_busy=0 → same cycle redirect_valid=1, redirect_pc=0x80000040, flush_d=flush_e=1; next cycle all 0.
- Branch during fetch wait: redirect with i_busy=1 for 3 cycles → REDIR_WAIT holds redirect_pc=0x80000040 through the cycle i_busy drops, with flush_d=1 on that cycle. Then RUN with outputs 0, even if e_target changes meanwhile.
- Divide, DIV_LAT=16: e_is_div=1 → stall_e=1 for 15 cycles, mdu_done=1 on the 16th cycle. Inject m_busy for 2 cycles mid-run → mdu_done lands on the 18th cycle.
- Freeze priority: m_busy=1 together with a load-use condition and e_branch_taken=1 → all four stalls=1, no flush, no redirect. On m_busy release, the redirect is issued.
- Async reset mid-MDU (cnt=7): assert reset between edges → all outputs 0 immediately. After release, state RUN and no mdu_done pulse.
